// File: rtl/calc_pkg.sv
// Shared definitions for the calculator command front end: word layout,
// field offsets and the issue FSM encoding.
package calc_pkg;

    localparam int CMD_W  = 19;
    localparam int RES_W  = 11;
    localparam int OP_MSB = 18;
    localparam int OP_LSB = 16;
    localparam int A_MSB  = 15;
    localparam int B_MSB  = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } cmd_t;

endpackage

// File: rtl/calc_cmd_fifo.sv
// Command FIFO: DEPTH x cmd_t storage, wrapping pointers, occupancy counter.
// Push when full and pop when empty are dropped here so callers cannot corrupt state.
module calc_cmd_fifo
    import calc_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  cmd_t          wdata,
    output cmd_t          head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    cmd_t          mem_q [DEPTH];
    cmd_t          mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/calc_cmd_driver.sv
// Sequential front end for the combinational calculator: buffers command words,
// issues one at a time, and returns {codigo, saida} on a valid/ready stream.
module calc_cmd_driver
    import calc_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CMD_W-1:0] cmd_data,
    output logic [2:0]       codigo,
    output logic [7:0]       entrada_A,
    output logic [7:0]       entrada_B,
    input  logic [7:0]       saida,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [RES_W-1:0] res_data,
    output logic [CW-1:0]    count
);

    state_e           state_q, state_d;
    cmd_t             head, wdata;
    logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic             capture, res_clear;
    logic [2:0]       codigo_q, codigo_d;
    logic [7:0]       a_q, a_d, b_q, b_d;
    logic             res_valid_q, res_valid_d;
    logic [RES_W-1:0] res_data_q, res_data_d;

    assign wdata     = '{op: cmd_data[OP_MSB:OP_LSB], a: cmd_data[A_MSB:B_MSB+1], b: cmd_data[B_MSB:0]};
    assign cmd_ready = ~fifo_full;
    assign fifo_push = cmd_valid & cmd_ready;

    calc_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (wdata),
        .head  (head),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (res_ready) state_d = fifo_empty ? IDLE : ISSUE;
            default: state_d = IDLE;
        endcase
    end

    // The WAIT handshake pops the next command directly, giving ISSUE/WAIT back-to-back.
    always_comb begin
        fifo_pop  = 1'b0;
        capture   = 1'b0;
        res_clear = 1'b0;
        case (state_q)
            IDLE:  fifo_pop = ~fifo_empty;
            ISSUE: capture  = 1'b1;
            WAIT: begin
                res_clear = res_ready;
                fifo_pop  = res_ready & ~fifo_empty;
            end
            default: ;
        endcase
    end

    always_comb begin
        codigo_d    = fifo_pop ? head.op : codigo_q;
        a_d         = fifo_pop ? head.a  : a_q;
        b_d         = fifo_pop ? head.b  : b_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        if (capture) begin
            res_valid_d = 1'b1;
            res_data_d  = {codigo_q, saida};
        end else if (res_clear) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            codigo_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            codigo_q    <= codigo_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    assign codigo    = codigo_q;
    assign entrada_A = a_q;
    assign entrada_B = b_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;

endmodule

// File: tb/tb_calc_cmd_driver.sv
// Directed + random bench for calc_cmd_driver with an adder stub as the calculator;
// results are scored against an in-order queue of expected {op, A+B} words.
module tb_calc_cmd_driver;
    import calc_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [CMD_W-1:0] cmd_data;
    logic [2:0]       codigo;
    logic [7:0]       entrada_A, entrada_B, saida;
    logic             res_valid, res_ready;
    logic [RES_W-1:0] res_data;
    logic [CW-1:0]    count;

    logic             noise_en = 1'b0;
    logic [7:0]       noise    = '0;

    int n_assert = 0;
    int n_fail   = 0;
    logic [RES_W-1:0] exp_q[$];
    logic [CMD_W-1:0] w;

    always #5 clk = ~clk;

    assign saida = noise_en ? noise : 8'(entrada_A + entrada_B);

    calc_cmd_driver #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .codigo    (codigo),
        .entrada_A (entrada_A),
        .entrada_B (entrada_B),
        .saida     (saida),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .count     (count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: score handshakes seen at this negedge, advance, then check invariants.
    task automatic step();
        logic             hold;
        logic [RES_W-1:0] held;
        if (cmd_valid && cmd_ready)
            exp_q.push_back({cmd_data[18:16], 8'(cmd_data[15:8] + cmd_data[7:0])});
        if (res_valid && res_ready) begin
            if (exp_q.size() == 0) chk("result_unexpected", 32'(exp_q.size()), 1);
            else                   chk("result_order", 32'(res_data), 32'(exp_q.pop_front()));
        end
        hold = res_valid && !res_ready;
        held = res_data;
        @(posedge clk);
        @(negedge clk);
        if (hold) begin
            chk("hold_valid", 32'(res_valid), 1);
            chk("hold_data", 32'(res_data), 32'(held));
        end
        chk("ready_decode", 32'(cmd_ready), 32'(count != CW'(DEPTH)));
        chk("count_bound", 32'(count <= CW'(DEPTH)), 1);
    endtask

    task automatic drain();
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0 && !res_valid && count == 0) break;
            step();
        end
        chk("drain_queue", 32'(exp_q.size()), 0);
        chk("drain_valid", 32'(res_valid), 0);
        chk("drain_count", 32'(count), 0);
    endtask

    task automatic wait_res();
        for (int i = 0; i < 20; i++) begin
            if (res_valid) break;
            step();
        end
        chk("res_valid_timeout", 32'(res_valid), 1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_codigo"}, 32'(codigo), 0);
        chk({tag, "_A"}, 32'(entrada_A), 0);
        chk({tag, "_B"}, 32'(entrada_B), 0);
        chk({tag, "_res_valid"}, 32'(res_valid), 0);
        chk({tag, "_res_data"}, 32'(res_data), 0);
        chk({tag, "_count"}, 32'(count), 0);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        res_ready = 1'b0;

        // Reset
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single command latency
        res_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_data  = {3'b001, 8'h05, 8'h03};
        step();
        cmd_valid = 1'b0;
        chk("single_count_E0", 32'(count), 1);
        chk("single_nobypass", 32'(codigo), 0);
        step();
        chk("single_codigo", 32'(codigo), 1);
        chk("single_A", 32'(entrada_A), 8'h05);
        chk("single_B", 32'(entrada_B), 8'h03);
        chk("single_valid_E1", 32'(res_valid), 0);
        step();
        chk("single_valid_E2", 32'(res_valid), 1);
        chk("single_data", 32'(res_data), {3'b001, 8'h08});
        step();
        chk("single_valid_E3", 32'(res_valid), 0);
        chk("single_idle_A", 32'(entrada_A), 8'h05);

        // Fill with backpressure: 5 accepted, 6th stalls
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1;
            cmd_data  = CMD_W'($urandom);
            chk("fill_ready", 32'(cmd_ready), 1);
            step();
        end
        chk("fill_count", 32'(count), DEPTH);
        chk("fill_full", 32'(cmd_ready), 0);
        chk("fill_valid", 32'(res_valid), 1);
        cmd_data = CMD_W'($urandom);
        noise_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            noise = 8'($urandom);
            step();
            chk("bp_count", 32'(count), DEPTH);
            chk("bp_data", 32'(res_data), 32'(exp_q[0]));
        end
        noise_en  = 1'b0;
        res_ready = 1'b1;
        step();
        chk("bp_release_valid", 32'(res_valid), 0);
        chk("bp_release_ready", 32'(cmd_ready), 1);
        step();
        cmd_valid = 1'b0;
        chk("bp_next_valid", 32'(res_valid), 1);
        chk("bp_sixth_count", 32'(count), DEPTH);
        drain();

        // Simultaneous push and pop at count=2
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1'b1;
            cmd_data  = CMD_W'($urandom);
            step();
        end
        cmd_valid = 1'b0;
        wait_res();
        chk("simul_pre_count", 32'(count), 2);
        cmd_valid = 1'b1;
        cmd_data  = CMD_W'($urandom);
        res_ready = 1'b1;
        step();
        cmd_valid = 1'b0;
        chk("simul_post_count", 32'(count), 2);
        drain();

        // Reset mid-WAIT with 3 queued
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cmd_valid = 1'b1;
            cmd_data  = CMD_W'($urandom);
            step();
        end
        cmd_valid = 1'b0;
        wait_res();
        chk("midrst_pre_count", 32'(count), 3);
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        res_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("midrst_no_stale", 32'(res_valid), 0);
        end

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cmd_valid = 1'($urandom);
            cmd_data  = CMD_W'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
